// File: rtl/in_service_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : in_service_unit_if
// Brief   : Command and status bundle between the priority resolver / control
//           logic and the clocked in-service register.
// Revision: 1.0 - initial release
// ============================================================================
interface in_service_unit_if #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] interrupt_grant;
    logic               latch_in_service;
    logic               second_ack;
    logic               auto_eoi_mode;
    logic               eoi_nonspecific;
    logic               eoi_specific;
    logic [IDX_W-1:0]   eoi_level;
    logic               rotate_on_eoi;
    logic [NUM_IRQ-1:0] in_service_register;
    logic               highest_in_service_valid;
    logic [IDX_W-1:0]   highest_in_service_index;
    logic [IDX_W-1:0]   lowest_priority;
    logic               eoi_error;

    modport master (
        output interrupt_grant, latch_in_service, second_ack, auto_eoi_mode,
               eoi_nonspecific, eoi_specific, eoi_level, rotate_on_eoi,
        input  in_service_register, highest_in_service_valid,
               highest_in_service_index, lowest_priority, eoi_error
    );

    modport slave (
        input  interrupt_grant, latch_in_service, second_ack, auto_eoi_mode,
               eoi_nonspecific, eoi_specific, eoi_level, rotate_on_eoi,
        output in_service_register, highest_in_service_valid,
               highest_in_service_index, lowest_priority, eoi_error
    );
endinterface
`default_nettype wire

// File: rtl/in_service_unit.sv
`default_nettype none
// ============================================================================
// Module  : in_service_unit
// Brief   : 8259A-style in-service register with EOI/AEOI clearing, rotating
//           priority pointer and registered EOI error flag.
// Revision: 1.0 - initial release
// ============================================================================
module in_service_unit #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    in_service_unit_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_lp_reset = IDX_W'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] r_isr;
    logic [IDX_W-1:0]   r_lowest_priority;
    logic [IDX_W-1:0]   r_last_idx;
    logic               r_last_valid;
    logic               r_eoi_error;

    logic [NUM_IRQ-1:0] w_clear;
    logic [NUM_IRQ-1:0] w_set;
    logic               w_error;
    logic               w_rot_valid;
    logic [IDX_W-1:0]   w_rot_idx;
    logic               w_last_valid_nxt;
    logic [IDX_W-1:0]   w_last_idx_nxt;
    logic               w_level_ok;
    logic [IDX_W:0]     w_isr_hi;
    logic [IDX_W:0]     w_grant_hi;

    // Returns {found, index} of the highest-priority set bit, scanning from the
    // lowest-priority offset upward so the highest-priority hit lands last.
    function automatic logic [IDX_W:0] pick_highest(
        input logic [NUM_IRQ-1:0] vec,
        input logic [IDX_W-1:0]   lp
    );
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] p;
        int               pos;
        result = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            pos = int'(lp) + 1 + i;
            if (pos >= NUM_IRQ) begin
                pos = pos - NUM_IRQ;
            end
            p = IDX_W'(pos);
            if (vec[p]) begin
                result = {1'b1, p};
            end
        end
        return result;
    endfunction

    generate
        if ((2 ** IDX_W) > NUM_IRQ) begin : g_level_check
            assign w_level_ok = (bus.eoi_level < IDX_W'(NUM_IRQ));
        end else begin : g_level_full
            assign w_level_ok = 1'b1;
        end
    endgenerate

    assign w_isr_hi   = pick_highest(r_isr, r_lowest_priority);
    assign w_grant_hi = pick_highest(bus.interrupt_grant, r_lowest_priority);

    // All clears and the latch look at pre-edge ISR and pre-edge priority order.
    always_comb begin
        w_clear          = '0;
        w_set            = '0;
        w_error          = 1'b0;
        w_rot_valid      = 1'b0;
        w_rot_idx        = '0;
        w_last_valid_nxt = r_last_valid;
        w_last_idx_nxt   = r_last_idx;

        if (bus.eoi_specific) begin
            if (w_level_ok) begin
                if (r_isr[bus.eoi_level]) begin
                    w_clear[bus.eoi_level] = 1'b1;
                    w_rot_valid            = 1'b1;
                    w_rot_idx              = bus.eoi_level;
                end else begin
                    w_error = 1'b1;
                end
            end
        end else if (bus.eoi_nonspecific) begin
            if (w_isr_hi[IDX_W]) begin
                w_clear[w_isr_hi[IDX_W-1:0]] = 1'b1;
                w_rot_valid                  = 1'b1;
                w_rot_idx                    = w_isr_hi[IDX_W-1:0];
            end else begin
                w_error = 1'b1;
            end
        end

        if (bus.auto_eoi_mode && bus.second_ack) begin
            if (r_last_valid && r_isr[r_last_idx]) begin
                w_clear[r_last_idx] = 1'b1;
                if (!w_rot_valid) begin
                    w_rot_valid = 1'b1;
                    w_rot_idx   = r_last_idx;
                end
            end else begin
                w_error = 1'b1;
            end
            w_last_valid_nxt = 1'b0;
        end

        if (bus.latch_in_service) begin
            if (w_grant_hi[IDX_W]) begin
                w_set[w_grant_hi[IDX_W-1:0]] = 1'b1;
                w_last_valid_nxt             = 1'b1;
                w_last_idx_nxt               = w_grant_hi[IDX_W-1:0];
            end else begin
                w_last_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_isr             <= '0;
            r_lowest_priority <= c_lp_reset;
            r_last_idx        <= '0;
            r_last_valid      <= 1'b0;
            r_eoi_error       <= 1'b0;
        end else begin
            r_isr        <= (r_isr & ~w_clear) | w_set;
            r_last_valid <= w_last_valid_nxt;
            r_last_idx   <= w_last_idx_nxt;
            r_eoi_error  <= w_error;
            if (bus.rotate_on_eoi && w_rot_valid) begin
                r_lowest_priority <= w_rot_idx;
            end
        end
    end

    assign bus.in_service_register      = r_isr;
    assign bus.highest_in_service_valid = w_isr_hi[IDX_W];
    assign bus.highest_in_service_index = w_isr_hi[IDX_W-1:0];
    assign bus.lowest_priority          = r_lowest_priority;
    assign bus.eoi_error                = r_eoi_error;

endmodule
`default_nettype wire

// File: tb/tb_in_service_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_in_service_unit
// Brief   : Directed scenarios plus randomized traffic against a rank-based
//           reference model of the in-service register.
// Revision: 1.0 - initial release
// ============================================================================
module tb_in_service_unit;
    localparam int N  = 8;
    localparam int IW = 3;

    logic clk;
    logic rst_s;
    int   checks;
    int   failures;
    bit   mode_aeoi;
    bit   mode_rot;

    logic [N-1:0] m_isr;
    int           m_lp;
    int           m_last;
    bit           m_err;

    in_service_unit_if #(.NUM_IRQ(N)) bus ();

    in_service_unit #(.NUM_IRQ(N)) dut (
        .clk   (clk),
        .reset (rst_s),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority rank 0 is the highest; rank grows with distance past lowest_priority.
    function automatic int hi_of(input logic [N-1:0] v, input int lp);
        int best;
        int br;
        best = -1;
        br   = N;
        for (int k = 0; k < N; k++) begin
            if (v[k] && (((k - lp - 1 + 2 * N) % N) < br)) begin
                br   = (k - lp - 1 + 2 * N) % N;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic model_step(input logic [N-1:0] g, input bit l, input bit sk,
                              input bit ens, input bit esp, input int lvl, input bit rs);
        logic [N-1:0] clr;
        logic [N-1:0] st;
        int           rot_k;
        int           h;
        bit           err;
        clr = '0; st = '0; rot_k = -1; err = 1'b0;
        if (rs) begin
            m_isr = '0; m_lp = N - 1; m_last = -1; m_err = 1'b0;
        end else begin
            if (esp) begin
                if (m_isr[lvl]) begin clr[lvl] = 1'b1; rot_k = lvl; end
                else err = 1'b1;
            end else if (ens) begin
                h = hi_of(m_isr, m_lp);
                if (h >= 0) begin clr[h] = 1'b1; rot_k = h; end
                else err = 1'b1;
            end
            if (mode_aeoi && sk) begin
                if (m_last >= 0 && m_isr[m_last]) begin
                    clr[m_last] = 1'b1;
                    if (rot_k < 0) rot_k = m_last;
                end else err = 1'b1;
                m_last = -1;
            end
            if (l) begin
                h = hi_of(g, m_lp);
                if (h >= 0) st[h] = 1'b1;
                m_last = h;
            end
            m_isr = (m_isr & ~clr) | st;
            if (mode_rot && rot_k >= 0) m_lp = rot_k;
            m_err = err;
        end
    endtask

    task automatic apply(input logic [N-1:0] g, input bit l, input bit sk, input bit ens,
                         input bit esp, input logic [IW-1:0] lvl, input bit rs);
        bus.interrupt_grant  = g;
        bus.latch_in_service = l;
        bus.second_ack       = sk;
        bus.eoi_nonspecific  = ens;
        bus.eoi_specific     = esp;
        bus.eoi_level        = lvl;
        bus.auto_eoi_mode    = mode_aeoi;
        bus.rotate_on_eoi    = mode_rot;
        rst_s                = rs;
        @(posedge clk);
        model_step(g, l, sk, ens, esp, int'(lvl), rs);
        #1;
    endtask

    task automatic test_reset;
        apply('0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.in_service_register !== 8'h00 || bus.lowest_priority !== 3'd7 ||
            bus.highest_in_service_valid !== 1'b0 || bus.highest_in_service_index !== 3'd0 ||
            bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL reset got isr=%h lp=%0d v=%b idx=%0d err=%b exp isr=00 lp=7 v=0 idx=0 err=0",
                     bus.in_service_register, bus.lowest_priority, bus.highest_in_service_valid,
                     bus.highest_in_service_index, bus.eoi_error);
        end
    endtask

    task automatic test_latch;
        apply(8'h04, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.in_service_register !== 8'h04 || bus.highest_in_service_index !== 3'd2 ||
            bus.highest_in_service_valid !== 1'b1) begin
            failures++;
            $display("FAIL latch got isr=%h idx=%0d v=%b exp isr=04 idx=2 v=1",
                     bus.in_service_register, bus.highest_in_service_index, bus.highest_in_service_valid);
        end
        apply('0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_nested_eoi;
        logic [N-1:0] exp_isr [3];
        logic [IW-1:0] exp_idx [3];
        logic exp_v [3];
        exp_isr = '{8'h22, 8'h20, 8'h00};
        exp_idx = '{3'd1, 3'd5, 3'd0};
        exp_v   = '{1'b1, 1'b1, 1'b0};
        apply(8'h20, 1, 0, 0, 0, 0, 0);
        apply(8'h02, 1, 0, 0, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (bus.in_service_register !== exp_isr[s] || bus.highest_in_service_index !== exp_idx[s] ||
                bus.highest_in_service_valid !== exp_v[s]) begin
                failures++;
                $display("FAIL nested_eoi step%0d got isr=%h idx=%0d v=%b exp isr=%h idx=%0d v=%b", s,
                         bus.in_service_register, bus.highest_in_service_index,
                         bus.highest_in_service_valid, exp_isr[s], exp_idx[s], exp_v[s]);
            end
            apply('0, 0, 0, 1, 0, 0, 0);
        end
        checks++;
        if (bus.eoi_error !== 1'b1) begin
            failures++;
            $display("FAIL nested_empty_err got=%b exp=1", bus.eoi_error);
        end
        apply('0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle got=%b exp=0", bus.eoi_error);
        end
    endtask

    task automatic test_specific;
        apply(8'h20, 1, 0, 0, 0, 0, 0);
        apply(8'h02, 1, 0, 0, 0, 0, 0);
        apply('0, 0, 0, 0, 1, 3'd5, 0);
        checks++;
        if (bus.in_service_register !== 8'h02 || bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL specific got isr=%h err=%b exp isr=02 err=0", bus.in_service_register, bus.eoi_error);
        end
        apply('0, 0, 0, 0, 1, 3'd5, 0);
        checks++;
        if (bus.in_service_register !== 8'h02 || bus.eoi_error !== 1'b1) begin
            failures++;
            $display("FAIL specific_err got isr=%h err=%b exp isr=02 err=1", bus.in_service_register, bus.eoi_error);
        end
        apply(8'h20, 1, 0, 0, 0, 0, 0);
        apply('0, 0, 0, 1, 1, 3'd5, 0);
        checks++;
        if (bus.in_service_register !== 8'h02 || bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL both_eoi got isr=%h err=%b exp isr=02 err=0", bus.in_service_register, bus.eoi_error);
        end
        apply('0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_aeoi;
        mode_aeoi = 1'b1;
        apply(8'h08, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.in_service_register !== 8'h08) begin
            failures++;
            $display("FAIL aeoi_latch got=%h exp=08", bus.in_service_register);
        end
        apply('0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.in_service_register !== 8'h00 || bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL aeoi_clear got isr=%h err=%b exp isr=00 err=0", bus.in_service_register, bus.eoi_error);
        end
        apply('0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.eoi_error !== 1'b1) begin
            failures++;
            $display("FAIL aeoi_err got=%b exp=1", bus.eoi_error);
        end
        mode_aeoi = 1'b0;
        apply('0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_rotation;
        mode_rot = 1'b1;
        apply(8'h10, 1, 0, 0, 0, 0, 0);
        apply('0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.lowest_priority !== 3'd4 || bus.in_service_register !== 8'h00) begin
            failures++;
            $display("FAIL rotate got lp=%0d isr=%h exp lp=4 isr=00", bus.lowest_priority, bus.in_service_register);
        end
        apply(8'h81, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.in_service_register !== 8'h80 || bus.highest_in_service_index !== 3'd7 ||
            bus.lowest_priority !== 3'd4) begin
            failures++;
            $display("FAIL rotated_latch got isr=%h idx=%0d lp=%0d exp isr=80 idx=7 lp=4",
                     bus.in_service_register, bus.highest_in_service_index, bus.lowest_priority);
        end
        mode_rot = 1'b0;
    endtask

    task automatic test_simultaneous;
        apply(8'h08, 1, 0, 0, 0, 0, 0);
        apply(8'h08, 1, 0, 0, 1, 3'd3, 0);
        checks++;
        if (bus.in_service_register !== 8'h88 || bus.eoi_error !== 1'b0) begin
            failures++;
            $display("FAIL set_wins got isr=%h err=%b exp isr=88 err=0", bus.in_service_register, bus.eoi_error);
        end
        apply(8'h08, 1, 0, 0, 0, 0, 1);
        checks++;
        if (bus.in_service_register !== 8'h00 || bus.lowest_priority !== 3'd7) begin
            failures++;
            $display("FAIL reset_override got isr=%h lp=%0d exp isr=00 lp=7",
                     bus.in_service_register, bus.lowest_priority);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] g;
        int           h;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) mode_aeoi = ~mode_aeoi;
            if ($urandom_range(0, 15) == 0) mode_rot  = ~mode_rot;
            g = ($urandom_range(0, 2) == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
            apply(g, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  IW'($urandom_range(0, N - 1)), $urandom_range(0, 60) == 0);
            h = hi_of(m_isr, m_lp);
            checks++;
            if (bus.in_service_register !== m_isr || bus.lowest_priority !== IW'(m_lp) ||
                bus.eoi_error !== m_err || bus.highest_in_service_valid !== (h >= 0) ||
                bus.highest_in_service_index !== ((h >= 0) ? IW'(h) : IW'(0))) begin
                failures++;
                $display("FAIL random c=%0d got isr=%h lp=%0d err=%b v=%b idx=%0d exp isr=%h lp=%0d err=%b hi=%0d",
                         c, bus.in_service_register, bus.lowest_priority, bus.eoi_error,
                         bus.highest_in_service_valid, bus.highest_in_service_index,
                         m_isr, m_lp, m_err, h);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mode_aeoi = 1'b0;
        mode_rot  = 1'b0;
        m_isr     = '0;
        m_lp      = N - 1;
        m_last    = -1;
        m_err     = 1'b0;
        test_reset();
        test_latch();
        test_nested_eoi();
        test_specific();
        test_aeoi();
        test_rotation();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/in_service_unit.md
# in_service_unit

Parametrised 8259A-style in-service register (ISR) with clocked state. It replaces the purely combinational 3-bit in-service logic. It latches the granted interrupt on the first INTA, clears bits on specific or non-specific EOI and in automatic-EOI mode, and maintains a rotating priority pointer. It sits between the priority resolver (source of `interrupt_grant`) and the control logic / cascade block, which consume `in_service_register` and `highest_in_service_index` for masking and vector generation.

## Interface
- `NUM_IRQ`, 8, number of interrupt levels (2..32)
- `IDX_W`, `$clog2(NUM_IRQ)`, width of level indices
- `clk` input 1: single clock; all state updates on rising edge
- `reset` input 1: synchronous, active-high
- `interrupt_grant` input NUM_IRQ: granted request from the priority resolver, nominally one-hot
- `latch_in_service` input 1: one-cycle pulse at the first INTA
- `second_ack` input 1: one-cycle pulse at the end of the second INTA
- `auto_eoi_mode` input 1: AEOI enable (ICW4)
- `eoi_nonspecific` input 1: one-cycle non-specific EOI command
- `eoi_specific` input 1: one-cycle specific EOI command
- `eoi_level` input IDX_W: target level for a specific EOI
- `rotate_on_eoi` input 1: rotate priority when a bit is cleared by EOI or AEOI
- `in_service_register` output NUM_IRQ: current ISR
- `highest_in_service_valid` output 1: ISR non-zero
- `highest_in_service_index` output IDX_W: highest-priority set ISR bit
- `lowest_priority` output IDX_W: rotation pointer; level (lowest_priority+1) mod NUM_IRQ is highest
- `eoi_error` output 1: one-cycle flag for an EOI or AEOI that cleared nothing

## Operation
- **State:** ISR (NUM_IRQ bits), `lowest_priority` (IDX_W), `last_latched` (IDX_W, plus a valid bit), `eoi_error`.
- **Reset:** ISR=0, `lowest_priority`=NUM_IRQ-1 (IR0 highest), `last_latched` invalid, `eoi_error`=0. Consequently `highest_in_service_valid`=0 and `highest_in_service_index`=0.
- **Priority order:** level (lowest_priority+1) mod NUM_IRQ is highest. Priority descends with increasing index, wrapping modulo NUM_IRQ.
- **Latch:** on `latch_in_service`, set the highest-priority bit of `interrupt_grant` under the current order. Non-one-hot grants are therefore resolved here. Record that bit's index in `last_latched`. A zero grant causes no ISR change and leaves `last_latched` invalid.
- **Non-specific EOI:** clear the highest-priority set ISR bit.
- **Specific EOI:** clear bit `eoi_level`. If `eoi_level` ≥ NUM_IRQ, treat it as no-op.
- **AEOI:** if `auto_eoi_mode`=1 and `second_ack`=1, clear bit `last_latched` (if valid), then invalidate `last_latched`.
- **Rotation:** when `rotate_on_eoi`=1 and a clear actually removes bit k, set `lowest_priority` to k.
- **eoi_error:** pulses for one cycle when an EOI or AEOI command finds its target bit already 0, or finds ISR empty. ISR is unchanged in that case.
- **Command priority:** if both EOI commands assert in the same cycle, specific wins and non-specific is ignored. AEOI and an EOI in the same cycle both apply; rotation uses the EOI's cleared index.
- **Evaluation order within one cycle:**
  - Clears are computed on the pre-edge ISR and the pre-edge priority order.
  - The latch is then applied, also using the pre-edge order.
  - If the same bit is both set and cleared, set wins.
- **Outputs:** `highest_in_service_*` are combinational from registered ISR and `lowest_priority`.

## Timing
- One-cycle latency: a command sampled at edge n is visible on `in_service_register`, `lowest_priority` and `highest_in_service_*` after edge n.
- `eoi_error` is registered. It is high for exactly the cycle after the faulty command.
- Reset asserted mid-operation overrides all commands in that cycle and restores reset values at the next edge.
- Command pulses held high for multiple cycles are treated as repeated commands, one per cycle.
- No handshake back-pressure; the block accepts a command every cycle.

## Test plan
- **Reset, then latch:** reset; grant=0000_0100, latch pulse → ISR=0x04, `highest_in_service_index`=2, valid=1 next cycle.
- **Nested non-specific EOI:** latch IR5, then latch IR1 → ISR=0x22, index=1. Non-specific EOI → ISR=0x20, index=5. Second EOI → ISR=0, valid=0.
- **Specific EOI and error:** ISR=0x22; `eoi_specific`, `eoi_level`=5 → ISR=0x02. Repeat with `eoi_level`=5 → ISR unchanged, `eoi_error`=1 for one cycle.
- **AEOI:** `auto_eoi_mode`=1; latch IR3 → ISR=0x08. `second_ack` → ISR=0x00, no error. A second `second_ack` → `eoi_error`=1.
- **Rotation:** `rotate_on_eoi`=1; latch IR4, non-specific EOI → `lowest_priority`=4. Then grant=0x81 latch → bit 7 set (IR5 is highest, so IR7 outranks IR0), index=7.
- **Simultaneous and reset:** ISR=0x08; same cycle latch grant=0x08 and specific EOI level 3 → ISR=0x08 (set wins). Assert reset together with a latch → ISR=0, `lowest_priority`=7.
